// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. Computes a - b (modulo 2^WIDTH) LSB-first,
// one bit per clock, through a single full-subtract cell with a registered
// borrow. Trades latency (WIDTH+2 cycles per operation including the accept
// edge) for the area of a parallel ripple chain.
//
// Handshake: start is sampled only while ready=1. The operands are captured on
// that accept edge. done pulses for one cycle when difference/borrow have been
// updated. difference/borrow hold until the next completion and never expose
// partial results.
//
// Optional feature (macro SIGNED_OVF_EN):
//   Adds output port 'overflow', the two's-complement overflow flag of a - b,
//   loaded together with difference/borrow at completion.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   start      in   1      operation request, sampled only when ready=1
//   a          in   WIDTH  minuend, captured on the accept edge
//   b          in   WIDTH  subtrahend, captured on the accept edge
//   ready      out  1      high in IDLE, decoded from the state register
//   done       out  1      single-cycle pulse, result valid
//   difference out  WIDTH  registered a - b modulo 2^WIDTH
//   borrow     out  1      registered final borrow (1 when a < b unsigned)
//   overflow   out  1      (SIGNED_OVF_EN only) signed overflow of a - b
//
// Parameter WIDTH: operand/result width, legal range 2..32.
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] difference,
`ifdef SIGNED_OVF_EN
    output logic             overflow,
`endif
    output logic             borrow
);

    // Counter just large enough to index WIDTH-1.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    // Holds the WIDTH-1 most recently produced bits; the bit being produced
    // this cycle completes the full word in sh_full_s.
    logic [WIDTH-2:0] sh_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;
`ifdef SIGNED_OVF_EN
    logic             a_msb_r;
    logic             b_msb_r;
`endif

    logic             d_s;
    logic             bo_s;
    logic [WIDTH-1:0] sh_full_s;
    logic             last_s;

    // Difference bit of the full-subtract cell.
    function automatic logic sub_diff(input logic x, input logic y, input logic bin);
        return x ^ y ^ bin;
    endfunction

    // Borrow-out of the full-subtract cell.
    function automatic logic sub_borrow(input logic x, input logic y, input logic bin);
        return (~x & y) | (~(x ^ y) & bin);
    endfunction

    // Single-bit subtract cell and next shift-register word.
    always_comb begin
        d_s       = sub_diff(a_r[0], b_r[0], br_r);
        bo_s      = sub_borrow(a_r[0], b_r[0], br_r);
        sh_full_s = {d_s, sh_r};
        last_s    = (cnt_r == CW'(WIDTH - 1));
    end

    // ready is a pure decode of the state register (no input-to-output path).
    always_comb begin
        if (state_r == ST_IDLE) begin
            ready = 1'b1;
        end else begin
            ready = 1'b0;
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            sh_r       <= {(WIDTH-1){1'b0}};
            br_r       <= 1'b0;
            cnt_r      <= {CW{1'b0}};
            done       <= 1'b0;
            difference <= {WIDTH{1'b0}};
            borrow     <= 1'b0;
`ifdef SIGNED_OVF_EN
            a_msb_r    <= 1'b0;
            b_msb_r    <= 1'b0;
            overflow   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        br_r    <= 1'b0;
                        cnt_r   <= {CW{1'b0}};
`ifdef SIGNED_OVF_EN
                        a_msb_r <= a[WIDTH-1];
                        b_msb_r <= b[WIDTH-1];
`endif
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    br_r  <= bo_s;
                    a_r   <= {1'b0, a_r[WIDTH-1:1]};
                    b_r   <= {1'b0, b_r[WIDTH-1:1]};
                    sh_r  <= sh_full_s[WIDTH-1:1];
                    cnt_r <= cnt_r + CW'(1);
                    if (last_s) begin
                        // The MSB is being produced now, so sh_full_s is the
                        // complete result and bo_s the final borrow.
                        difference <= sh_full_s;
                        borrow     <= bo_s;
`ifdef SIGNED_OVF_EN
                        overflow   <= (a_msb_r ^ b_msb_r) & (a_msb_r ^ d_s);
`endif
                        done       <= 1'b1;
                        state_r    <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed self-checking bench for serial_subtractor (WIDTH=8). Inputs are
// driven and outputs sampled on the falling clock edge. Each test task
// compares DUT outputs against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       done;
    logic [7:0] difference;
    logic       borrow;
`ifdef SIGNED_OVF_EN
    logic       overflow;
`endif

    int total;
    int bad;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .ready      (ready),
        .done       (done),
        .difference (difference),
`ifdef SIGNED_OVF_EN
        .overflow   (overflow),
`endif
        .borrow     (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation and measure it. lat = edges after the accept edge
    // at which done was first seen (99 if never). rdy_ok = ready stayed low
    // from the accept edge to done. Samples taken at the done cycle and one
    // cycle later.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          output int lat, output logic [7:0] diff,
                          output logic brw, output logic rdy_ok,
                          output logic rdy_at_done, output logic done_after,
                          output logic rdy_after);
        int n;
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        a     = 8'hA5;
        b     = 8'h5A;
        n      = 0;
        rdy_ok = 1'b1;
        while (n < 20 && done !== 1'b1) begin
            if (ready !== 1'b0) rdy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        lat         = (done === 1'b1) ? n : 99;
        diff        = difference;
        brw         = borrow;
        rdy_at_done = ready;
        @(negedge clk);
        done_after = done;
        rdy_after  = ready;
    endtask

    task automatic test_reset;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        rst   = 1'b1;
        #2;
        total += 4;
        if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        if (difference !== 8'h00) begin bad++; $display("FAIL reset_diff got=%h exp=00", difference); end
        if (borrow !== 1'b0) begin bad++; $display("FAIL reset_borrow got=%b exp=0", borrow); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total += 1;
        if (ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", ready); end
    endtask

    task automatic test_basic;
        int lat; logic [7:0] d; logic br, rok, rdn, dna, rda;
        run_op(8'd9, 8'd5, lat, d, br, rok, rdn, dna, rda);
        total += 7;
        if (lat !== 8) begin bad++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        if (d !== 8'h04) begin bad++; $display("FAIL basic_diff got=%h exp=04", d); end
        if (br !== 1'b0) begin bad++; $display("FAIL basic_borrow got=%b exp=0", br); end
        if (rok !== 1'b1) begin bad++; $display("FAIL basic_ready_low got=%b exp=1", rok); end
        if (rdn !== 1'b0) begin bad++; $display("FAIL basic_ready_at_done got=%b exp=0", rdn); end
        if (dna !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", dna); end
        if (rda !== 1'b1) begin bad++; $display("FAIL basic_ready_after got=%b exp=1", rda); end
    endtask

    task automatic test_wrap;
        int lat; logic [7:0] d; logic br, rok, rdn, dna, rda;
        run_op(8'd5, 8'd9, lat, d, br, rok, rdn, dna, rda);
        total += 2;
        if (d !== 8'hFC) begin bad++; $display("FAIL wrap1_diff got=%h exp=fc", d); end
        if (br !== 1'b1) begin bad++; $display("FAIL wrap1_borrow got=%b exp=1", br); end
        run_op(8'h00, 8'h01, lat, d, br, rok, rdn, dna, rda);
        total += 3;
        if (d !== 8'hFF) begin bad++; $display("FAIL wrap2_diff got=%h exp=ff", d); end
        if (br !== 1'b1) begin bad++; $display("FAIL wrap2_borrow got=%b exp=1", br); end
        if (lat !== 8) begin bad++; $display("FAIL wrap2_latency got=%0d exp=8", lat); end
    endtask

    task automatic test_equal;
        int lat; logic [7:0] d; logic br, rok, rdn, dna, rda;
        run_op(8'h00, 8'h00, lat, d, br, rok, rdn, dna, rda);
        total += 2;
        if (d !== 8'h00) begin bad++; $display("FAIL eq0_diff got=%h exp=00", d); end
        if (br !== 1'b0) begin bad++; $display("FAIL eq0_borrow got=%b exp=0", br); end
        run_op(8'hFF, 8'hFF, lat, d, br, rok, rdn, dna, rda);
        total += 2;
        if (d !== 8'h00) begin bad++; $display("FAIL eqff_diff got=%h exp=00", d); end
        if (br !== 1'b0) begin bad++; $display("FAIL eqff_borrow got=%b exp=0", br); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total += 1;
            if (difference !== 8'h00 || borrow !== 1'b0) begin
                bad++;
                $display("FAIL eq_hold got=%h/%b exp=00/0", difference, borrow);
            end
        end
    endtask

    task automatic test_busy;
        int n; int extra;
        int lat; logic [7:0] d; logic br, rok, rdn, dna, rda;
        @(negedge clk);
        start = 1'b1; a = 8'd20; b = 8'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // RUN cycle 3: offer a new operation while busy and keep offering it.
        start = 1'b1; a = 8'd1; b = 8'd2;
        n = 2;
        while (n < 20 && done !== 1'b1) begin
            total += 1;
            if (difference !== 8'h00) begin bad++; $display("FAIL busy_hold got=%h exp=00", difference); end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        total += 3;
        if (n !== 8) begin bad++; $display("FAIL busy_latency got=%0d exp=8", n); end
        if (difference !== 8'd17) begin bad++; $display("FAIL busy_diff got=%0d exp=17", difference); end
        if (borrow !== 1'b0) begin bad++; $display("FAIL busy_borrow got=%b exp=0", borrow); end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        total += 2;
        if (extra !== 0) begin bad++; $display("FAIL busy_single_done got=%0d exp=0", extra); end
        if (ready !== 1'b1) begin bad++; $display("FAIL busy_ready got=%b exp=1", ready); end
        run_op(8'd1, 8'd2, lat, d, br, rok, rdn, dna, rda);
        total += 2;
        if (d !== 8'hFF) begin bad++; $display("FAIL busy_next_diff got=%h exp=ff", d); end
        if (br !== 1'b1) begin bad++; $display("FAIL busy_next_borrow got=%b exp=1", br); end
    endtask

    task automatic test_back_to_back;
        int first; int second;
        first  = -1;
        second = -1;
        @(negedge clk);
        start = 1'b1; a = 8'd3; b = 8'd1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            if (second >= 0) break;
        end
        start = 1'b0;
        total += 3;
        if (first < 0 || second < 0) begin bad++; $display("FAIL b2b_seen got=%0d/%0d exp=two pulses", first, second); end
        if (second - first !== 10) begin bad++; $display("FAIL b2b_period got=%0d exp=10", second - first); end
        if (difference !== 8'd2) begin bad++; $display("FAIL b2b_diff got=%0d exp=2", difference); end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int spurious;
        int lat; logic [7:0] d; logic br, rok, rdn, dna, rda;
        @(negedge clk);
        start = 1'b1; a = 8'd50; b = 8'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total += 4;
        if (ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", ready); end
        if (done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b exp=0", done); end
        if (difference !== 8'h00) begin bad++; $display("FAIL mid_diff got=%h exp=00", difference); end
        if (borrow !== 1'b0) begin bad++; $display("FAIL mid_borrow got=%b exp=0", borrow); end
        @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) spurious++;
        end
        total += 1;
        if (spurious !== 0) begin bad++; $display("FAIL mid_no_done got=%0d exp=0", spurious); end
        run_op(8'd100, 8'd1, lat, d, br, rok, rdn, dna, rda);
        total += 3;
        if (d !== 8'd99) begin bad++; $display("FAIL mid_next_diff got=%0d exp=99", d); end
        if (br !== 1'b0) begin bad++; $display("FAIL mid_next_borrow got=%b exp=0", br); end
        if (lat !== 8) begin bad++; $display("FAIL mid_next_latency got=%0d exp=8", lat); end
    endtask

`ifdef SIGNED_OVF_EN
    task automatic test_overflow;
        int lat; logic [7:0] d; logic br, rok, rdn, dna, rda;
        run_op(8'h80, 8'h01, lat, d, br, rok, rdn, dna, rda);
        total += 3;
        if (d !== 8'h7F) begin bad++; $display("FAIL ovf1_diff got=%h exp=7f", d); end
        if (br !== 1'b0) begin bad++; $display("FAIL ovf1_borrow got=%b exp=0", br); end
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf1_flag got=%b exp=1", overflow); end
        run_op(8'h7F, 8'hFF, lat, d, br, rok, rdn, dna, rda);
        total += 3;
        if (d !== 8'h80) begin bad++; $display("FAIL ovf2_diff got=%h exp=80", d); end
        if (br !== 1'b1) begin bad++; $display("FAIL ovf2_borrow got=%b exp=1", br); end
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf2_flag got=%b exp=1", overflow); end
        run_op(8'h10, 8'h01, lat, d, br, rok, rdn, dna, rda);
        total += 2;
        if (d !== 8'h0F) begin bad++; $display("FAIL ovf3_diff got=%h exp=0f", d); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL ovf3_flag got=%b exp=0", overflow); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_equal();
        test_busy();
        test_back_to_back();
        test_reset_mid();
`ifdef SIGNED_OVF_EN
        test_overflow();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
